// File: rtl/mig_tt_scheduler.sv
// Time-multiplexed MAJ3 evaluator: sweeps a small MIG node program over all 128
// input patterns, builds the truth table, then compares it with tt_exp. Optional macro: MIG_INV_EN.
module mig_tt_scheduler #(
    parameter int MAX_NODES = 8,
    parameter int SEL_W     = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_we,
    input  logic [2:0]         cfg_node,
    input  logic [SEL_W-1:0]   cfg_sel_a,
    input  logic [SEL_W-1:0]   cfg_sel_b,
    input  logic [SEL_W-1:0]   cfg_sel_c,
    input  logic [2:0]         cfg_inv,
    input  logic [3:0]         num_nodes,
    input  logic [127:0]       tt_exp,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               match,
    output logic [127:0]       tt
);

    localparam int K_W = $clog2(MAX_NODES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [6:0]             p_q, p_d;
    logic [K_W-1:0]         k_q, k_d;
    logic [3:0]             n_q, n_d;
    logic [MAX_NODES-1:0]   w_q, w_d;
    logic [127:0]           tt_q, tt_d;
    logic                   err_q, err_d;
    logic                   match_q, match_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic [SEL_W-1:0]       sel_a_q [MAX_NODES];
    logic [SEL_W-1:0]       sel_b_q [MAX_NODES];
    logic [SEL_W-1:0]       sel_c_q [MAX_NODES];
    logic [SEL_W-1:0]       sel_a_d [MAX_NODES];
    logic [SEL_W-1:0]       sel_b_d [MAX_NODES];
    logic [SEL_W-1:0]       sel_c_d [MAX_NODES];
`ifdef MIG_INV_EN
    logic [2:0]             inv_q [MAX_NODES];
    logic [2:0]             inv_d [MAX_NODES];
`else
    logic                   unused_cfg_inv;
    assign unused_cfg_inv = ^cfg_inv;
`endif

    logic [MAX_NODES-1:0]   slot_we;
    logic [2:0]             op_v;
    logic                   maj_v;
    logic                   illegal;
    logic [4:0]             fwd_lim;
    logic                   last_node;

    // The program store is frozen for the whole run; writes only land in IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_NODES; gi++) begin : g_slot_we
            assign slot_we[gi] = cfg_we && (state_q == S_IDLE) && (cfg_node == K_W'(gi));
        end
    endgenerate

    function automatic logic operand_value(input logic [SEL_W-1:0]     sel,
                                           input logic [6:0]           pat,
                                           input logic [MAX_NODES-1:0] w);
        logic v;
        if (sel == '0)
            v = 1'b0;
        else if (sel < SEL_W'(8))
            v = pat[3'(sel - SEL_W'(1))];
        else
            v = w[sel[K_W-1:0]];
        return v;
    endfunction

    assign fwd_lim   = 5'd8 + 5'(k_q);
    assign last_node = ({1'b0, k_q} == (n_q - 4'd1));

    always_comb begin
        op_v[0] = operand_value(sel_a_q[k_q], p_q, w_q);
        op_v[1] = operand_value(sel_b_q[k_q], p_q, w_q);
        op_v[2] = operand_value(sel_c_q[k_q], p_q, w_q);
`ifdef MIG_INV_EN
        op_v = op_v ^ inv_q[k_q];
`endif
        maj_v = (op_v[0] & op_v[1]) | (op_v[0] & op_v[2]) | (op_v[1] & op_v[2]);
        // A node may only read strictly earlier nodes; anything else would see stale data.
        illegal = ({1'b0, sel_a_q[k_q]} >= fwd_lim) ||
                  ({1'b0, sel_b_q[k_q]} >= fwd_lim) ||
                  ({1'b0, sel_c_q[k_q]} >= fwd_lim);
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        k_d     = k_q;
        n_d     = n_q;
        w_d     = w_q;
        tt_d    = tt_q;
        err_d   = err_q;
        match_d = match_q;
        sel_a_d = sel_a_q;
        sel_b_d = sel_b_q;
        sel_c_d = sel_c_q;
`ifdef MIG_INV_EN
        inv_d   = inv_q;
`endif
        for (int i = 0; i < MAX_NODES; i++) begin
            if (slot_we[i]) begin
                sel_a_d[i] = cfg_sel_a;
                sel_b_d[i] = cfg_sel_b;
                sel_c_d[i] = cfg_sel_c;
`ifdef MIG_INV_EN
                inv_d[i]   = cfg_inv;
`endif
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    match_d = 1'b0;
                    if (num_nodes == 4'd0 || num_nodes > 4'(MAX_NODES)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        n_d     = num_nodes;
                        tt_d    = '0;
                        err_d   = 1'b0;
                        p_d     = '0;
                        k_d     = '0;
                        state_d = S_EVAL;
                    end
                end
            end
            S_EVAL: begin
                if (illegal) begin
                    err_d   = 1'b1;
                    match_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    w_d[k_q] = maj_v;
                    if (last_node) begin
                        tt_d[p_q] = maj_v;
                        k_d       = '0;
                        if (p_q == 7'd127)
                            state_d = S_DONE;
                        else
                            p_d = p_q + 7'd1;
                    end else begin
                        k_d = k_q + K_W'(1);
                    end
                end
            end
            S_DONE: begin
                match_d = !err_q && (tt_q == tt_exp);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            k_q     <= '0;
            n_q     <= '0;
            w_q     <= '0;
            tt_q    <= '0;
            err_q   <= 1'b0;
            match_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < MAX_NODES; i++) begin
                sel_a_q[i] <= '0;
                sel_b_q[i] <= '0;
                sel_c_q[i] <= '0;
`ifdef MIG_INV_EN
                inv_q[i]   <= '0;
`endif
            end
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            k_q     <= k_d;
            n_q     <= n_d;
            w_q     <= w_d;
            tt_q    <= tt_d;
            err_q   <= err_d;
            match_q <= match_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            sel_c_q <= sel_c_d;
`ifdef MIG_INV_EN
            inv_q   <= inv_d;
`endif
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign err   = err_q;
    assign match = match_q;
    assign tt    = tt_q;

endmodule

// File: doc/mig_tt_scheduler.md
Name: mig_tt_scheduler

Overview:
- Time-multiplexed evaluator for majority-inverter graph (MIG) networks of up to 8 MAJ3 nodes over 7 primary inputs x0..x6.
- A small node program is loaded through a config port. On start, the block sequences one shared MAJ3 unit through every node for all 128 input patterns and assembles the 128-bit truth table.
- It then compares the table against an expected table. It sits beside the classification flow as the hardware checker of candidate networks.

Parameters:
- MAX_NODES, 8, node slots in the program store; fixed so operand select fits 4 bits.
- SEL_W, 4, operand select width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  write one node slot; ignored while busy.
- cfg_node  in  3  slot index written.
- cfg_sel_a, cfg_sel_b, cfg_sel_c  in  4 each  operand selects: 0=const0, 1..7=x0..x6, 8..15=w0..w7.
- cfg_inv  in  3  per-operand invert {c,b,a}; used only with MIG_INV_EN.
- num_nodes  in  4  active node count N, sampled on accepted start.
- tt_exp  in  128  expected truth table, sampled at DONE.
- start  in  1  begin run; accepted only in IDLE.
- busy  out  1  high in EVAL and DONE.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  run aborted on illegal program; held until next accepted start.
- match  out  1  tt == tt_exp at completion; held until next accepted start.
- tt  out  128  truth table; bit p = network output for pattern p, where x_i = p[i].

Behaviour:
- Reset: IDLE; pattern and node counters 0; all program slots cleared to sel 0 and inv 0; node registers w0..w7 cleared to 0; tt, done, err, match, busy all 0. Reset overrides everything mid-run: the run is discarded and done is not pulsed.
- FSM states: IDLE -> EVAL -> DONE -> IDLE.
- IDLE: start accepted in cycle T.
  - If N==0 or N>8: go to DONE with err=1 (done at T+1).
  - Otherwise: latch N, clear tt, err and match, set pattern p=0 and node k=0.
- EVAL: one node per cycle. Pattern p, node k is evaluated in cycle T+1+p*N+k.
  - Operand value: sel 0 -> 0; sel 1..7 -> p[sel-1]; sel 8+j -> w_j.
  - w_k <= MAJ3(a,b,c) = ab|ac|bc.
  - Legality: any sel >= 8+k (forward or self reference) -> no write; next state DONE with err=1, match=0, tt left partial.
  - k==N-1: tt[p] <= MAJ3 result. If p==127, next state is DONE; else p++ and k=0.
  - k<N-1: k++.
  - Node registers are not cleared between patterns. Legal programs never read stale values.
- DONE: exactly one cycle; done=1.
  - match <= (tt == tt_exp) when err==0, else 0.
  - Next state IDLE.
  - Successful run: done at T+128*N+1.
- start while busy: ignored. cfg_we while busy: ignored; the program is stable during a run.
- start and cfg_we in the same IDLE cycle: the write lands and the run begins next cycle. The run uses the pre-write slot for that cycle; the write is visible from EVAL onward, which is the first read.
- tt, err and match hold their values in IDLE until the next accepted start.

Optional Feature:
- MIG_INV_EN defined: each operand is XORed with its cfg_inv bit before MAJ3. Inverted const0 gives constant 1, which yields AND/OR nodes.
- Not defined: inv bits are neither stored nor used, and the cfg_inv port is ignored. The evaluator is pure majority.
- Timing is identical in both builds.

Test Plan:
- Load w0=(4,5,7), w1=(1,2,3), w2=(5,6,8), w3=(4,6,7), w4=(3,10,11), w5=(1,9,12); N=6; tt_exp=0xeaeaeae8eae8e8a8eae8e8a8e8a8a8a8; start at T -> done at T+769, tt equals tt_exp, match=1, err=0.
- Single node w0=(1,2,3), N=1 -> done at T+129, tt=0xE8 repeated 16 times; tt_exp=0 gives match=0.
- w0=(8,1,2), N=1 -> err=1 and done at T+2; match=0; tt bit 0 unchanged (0).
- Assert rst at T+300 during the first test -> next cycle busy=0, tt=0, no done pulse, program cleared; a restart with N=1 (all slots sel 0) gives tt=0.
- During a run, pulse start and cfg_we on slot 0 -> run unaffected and completes at the original cycle; slot 0 keeps its old program.
- MIG_INV_EN: w0=(1,0,2), inv=3'b010, N=1 -> tt=0xEE repeated 16 times (x0|x1). Without the macro, the same stimulus gives 0x88 repeated 16 times (x0&x1).
